dma_streamer: RTL and testbench

- Splits one DMA descriptor into a sequence of AXI burst requests for the DMA AXI interface.
- One instance per direction. STREAM_RD=1 drives the read (AR) side from the source address; STREAM_RD=0 drives the write (AW) side from the destination address.
- Sits between the DMA FSM/CSR (descriptor, go, abort) and the DMA AXI interface (request/ready handshake).
- Enforces bus-aligned addresses, the max-beat burst limit and the AXI 4KB boundary rule.

---
 rtl/dma_streamer.sv | 155 +++++++++++++++
 tb/tb_dma_streamer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_streamer.sv
// dma_streamer: splits one DMA descriptor into AXI burst requests.
// Each burst is bus-aligned, limited to MAX_BEATS (or one beat) and never
// crosses a 4KB boundary.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   dma_go_i             start pulse; descriptor sampled in the same cycle
//   dma_abort_i          abort the running descriptor
//   src_addr_i           descriptor source address (used when STREAM_RD=1)
//   dst_addr_i           descriptor destination address (used when STREAM_RD=0)
//   num_bytes_i          transfer length in bytes
//   req_*                burst request (valid/ready handshake to the AXI side)
//   busy_o, done_o       running flag, one-cycle completion pulse
//   err_*                alignment error pulse, offending address and code
module dma_streamer #(
  parameter int unsigned DATA_W       = 32,
  parameter bit          STREAM_RD    = 1'b1,
  parameter int unsigned MAX_BEATS    = 256,
  parameter bit          MAX_BURST_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dma_go_i,
  input  logic                dma_abort_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [31:0]         num_bytes_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic [31:0]         req_addr_o,
  output logic [7:0]          req_alen_o,
  output logic [2:0]          req_size_o,
  output logic [DATA_W/8-1:0] req_strb_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_valid_o,
  output logic [31:0]         err_addr_o,
  output logic [1:0]          err_src_o
);

  localparam int unsigned BPB     = DATA_W / 8;
  localparam int unsigned LOG_BPB = $clog2(BPB);
  localparam int unsigned LIM     = MAX_BURST_EN ? MAX_BEATS : 1;
  localparam logic [31:0] OFS_MASK = 32'(BPB - 1);
  localparam logic [1:0]  DMA_UNALIGNED_ERR = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] cur_addr;
  logic [31:0] bytes_left;

  // Beats in the next burst: min(beats left, beats to 4KB edge, limit).
  function automatic logic [8:0] burst_of(input logic [11:0] addr_lo,
                                          input logic [31:0] bytes);
    logic [31:0] beats_left;
    logic [12:0] beats_4k;
    logic [31:0] m;
    beats_left = bytes >> LOG_BPB;
    beats_4k   = (13'd4096 - {1'b0, addr_lo}) >> LOG_BPB;
    m = beats_left;
    if (32'(beats_4k) < m) m = 32'(beats_4k);
    if (32'(LIM) < m)      m = 32'(LIM);
    return 9'(m);
  endfunction

  logic [31:0] sel_addr;
  logic [31:0] step;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_bytes;
  logic [8:0]  go_burst;
  logic [8:0]  nxt_burst;
  logic        hs;
  logic        go_bad;

  assign sel_addr  = STREAM_RD ? src_addr_i : dst_addr_i;
  assign hs        = req_valid_o && req_ready_i;
  // req_alen_o always holds the current burst length minus one
  assign step      = 32'({1'b0, req_alen_o} + 9'd1) << LOG_BPB;
  assign nxt_addr  = cur_addr + step;
  assign nxt_bytes = bytes_left - step;
  assign go_burst  = burst_of(sel_addr[11:0], num_bytes_i);
  assign nxt_burst = burst_of(nxt_addr[11:0], nxt_bytes);
  assign go_bad    = ((sel_addr & OFS_MASK) != 32'd0) ||
                     ((num_bytes_i & OFS_MASK) != 32'd0);
  assign req_addr_o = cur_addr;

  // Descriptor FSM with registered request/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= 32'd0;
      bytes_left  <= 32'd0;
      req_valid_o <= 1'b0;
      req_alen_o  <= 8'd0;
      req_size_o  <= 3'd0;
      req_strb_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_valid_o <= 1'b0;
      err_addr_o  <= 32'd0;
      err_src_o   <= 2'd0;
    end else begin
      done_o      <= 1'b0;
      err_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_go_i) begin
            if (go_bad) begin
              err_valid_o <= 1'b1;
              err_addr_o  <= sel_addr;
              err_src_o   <= DMA_UNALIGNED_ERR;
            end else begin
              err_addr_o <= 32'd0;
              err_src_o  <= 2'd0;
              if (num_bytes_i == 32'd0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state       <= RUN;
                cur_addr    <= sel_addr;
                bytes_left  <= num_bytes_i;
                req_valid_o <= 1'b1;
                busy_o      <= 1'b1;
                req_alen_o  <= 8'(go_burst - 9'd1);
                req_size_o  <= 3'(LOG_BPB);
                req_strb_o  <= '1;
              end
            end
          end
        end
        RUN: begin
          // An accepted burst always counts, even when aborted this cycle
          if (hs) begin
            cur_addr   <= nxt_addr;
            bytes_left <= nxt_bytes;
            req_alen_o <= (nxt_bytes == 32'd0) ? 8'd0 : 8'(nxt_burst - 9'd1);
          end
          if (dma_abort_i) begin
            state       <= IDLE;
            req_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end else if (hs && (nxt_bytes == 32'd0)) begin
            state       <= DONE;
            req_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_streamer.sv
// tb_dma_streamer: table-driven descriptor jobs with a request scoreboard,
// plus hand-written stall, abort, reset and single-beat sequences.
module tb_dma_streamer;

  logic        clk, rst;
  logic        go0, go1, abort, ready;
  logic [31:0] src, dst, nbytes;

  logic        valid0, busy0, done0, errv0;
  logic [31:0] addr0, erra0;
  logic [7:0]  alen0;
  logic [2:0]  size0;
  logic [3:0]  strb0;
  logic [1:0]  errs0;

  logic        valid1, busy1, done1, errv1;
  logic [31:0] addr1, erra1;
  logic [7:0]  alen1;
  logic [2:0]  size1;
  logic [3:0]  strb1;
  logic [1:0]  errs1;

  dma_streamer #(.DATA_W(32), .STREAM_RD(1'b1), .MAX_BEATS(256), .MAX_BURST_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .dma_go_i(go0), .dma_abort_i(abort),
    .src_addr_i(src), .dst_addr_i(dst), .num_bytes_i(nbytes),
    .req_valid_o(valid0), .req_ready_i(ready), .req_addr_o(addr0),
    .req_alen_o(alen0), .req_size_o(size0), .req_strb_o(strb0),
    .busy_o(busy0), .done_o(done0), .err_valid_o(errv0),
    .err_addr_o(erra0), .err_src_o(errs0));

  dma_streamer #(.DATA_W(32), .STREAM_RD(1'b0), .MAX_BEATS(256), .MAX_BURST_EN(1'b0)) u_single (
    .clk(clk), .rst(rst), .dma_go_i(go1), .dma_abort_i(abort),
    .src_addr_i(src), .dst_addr_i(dst), .num_bytes_i(nbytes),
    .req_valid_o(valid1), .req_ready_i(ready), .req_addr_o(addr1),
    .req_alen_o(alen1), .req_size_o(size1), .req_strb_o(strb1),
    .busy_o(busy1), .done_o(done1), .err_valid_o(errv1),
    .err_addr_o(erra1), .err_src_o(errs1));

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] nbytes;
    int          nreq;
    logic [7:0]  alen0;
    bit          err;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vec [NVEC];
  req_t q [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [7:0]  prev_alen = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference split of a descriptor into bursts (32-bit bus, 256-beat limit).
  function automatic void push_model(input logic [31:0] a_in, input logic [31:0] b_in, input int limit);
    logic [31:0] a, b, m, b4k;
    int n;
    a = a_in; b = b_in; n = 0;
    while (b != 32'd0 && n < limit) begin
      m   = b / 4;
      b4k = (32'd4096 - (a % 32'd4096)) / 4;
      if (b4k < m) m = b4k;
      if (m > 32'd256) m = 32'd256;
      q.push_back('{addr: a, alen: 8'(m - 32'd1)});
      a = a + m * 4;
      b = b - m * 4;
      n++;
    end
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("busy_eq_valid", 32'(busy0), 32'(valid0));
      if (prev_stall && valid0) begin
        check("stall_addr", addr0, prev_addr);
        check("stall_alen", 32'(alen0), 32'(prev_alen));
      end
      if (valid0 && ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got addr %h alen %0d, required no request", addr0, alen0);
        end else begin
          req_t e;
          e = q.pop_front();
          check("req_addr", addr0, e.addr);
          check("req_alen", 32'(alen0), 32'(e.alen));
          check("req_size", 32'(size0), 32'd2);
          check("req_strb", 32'(strb0), 32'hF);
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      prev_stall = valid0 && !ready;
      prev_addr  = addr0;
      prev_alen  = alen0;
    end
  end

  // Returns one cycle after go was sampled, 1 time unit after the edge.
  task automatic do_go(input logic [31:0] a, input logic [31:0] n);
    @(posedge clk); #1;
    src = a; dst = a ^ 32'h2; nbytes = n; go0 = 1'b1;
    @(posedge clk); #1;
    go0 = 1'b0;
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    int t;
    v = vec[idx];
    if (!v.err) push_model(v.addr, v.nbytes, 10000);
    hs_cnt = 0;
    ready = 1'b1;
    do_go(v.addr, v.nbytes);
    @(negedge clk);
    if (v.err) begin
      check("err_valid", 32'(errv0), 32'd1);
      check("err_addr", erra0, v.addr);
      check("err_src", 32'(errs0), 32'd2);
      check("err_no_valid", 32'(valid0), 32'd0);
      @(negedge clk);
      check("err_pulse_end", 32'(errv0), 32'd0);
      check("err_addr_hold", erra0, v.addr);
      check("err_busy", 32'(busy0), 32'd0);
    end else if (v.nbytes == 32'd0) begin
      check("zero_done", 32'(done0), 32'd1);
      check("zero_valid", 32'(valid0), 32'd0);
      @(negedge clk);
      check("zero_done_end", 32'(done0), 32'd0);
      check("zero_nreq", 32'(hs_cnt), 32'd0);
    end else begin
      check("first_valid", 32'(valid0), 32'd1);
      check("first_addr", addr0, v.addr);
      check("first_alen", 32'(alen0), 32'(v.alen0));
      t = 0;
      while (!done0 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("done_seen", 32'(done0), 32'd1);
      check("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
      check("nreq", 32'(hs_cnt), 32'(v.nreq));
      check("queue_empty", 32'(q.size()), 32'd0);
      @(negedge clk);
      check("done_pulse_end", 32'(done0), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; go0 = 1'b0; go1 = 1'b0; abort = 1'b0; ready = 1'b1;
    src = 32'd0; dst = 32'd0; nbytes = 32'd0;

    vec[0] = '{32'h0000_1000, 32'd64,     1, 8'd15,  1'b0};
    vec[1] = '{32'h0000_0FF0, 32'h40,     2, 8'd3,   1'b0};
    vec[2] = '{32'h0000_2000, 32'h800,    2, 8'd255, 1'b0};
    vec[3] = '{32'h0000_1002, 32'd64,     0, 8'd0,   1'b1};
    vec[4] = '{32'h0000_1000, 32'd6,      0, 8'd0,   1'b1};
    vec[5] = '{32'h0000_3000, 32'd0,      0, 8'd0,   1'b0};
    vec[6] = '{32'h0000_0FFC, 32'h1008,   6, 8'd0,   1'b0};
    vec[7] = '{32'h0000_5400, 32'h404,    2, 8'd255, 1'b0};
    vec[8] = '{32'h0000_7F00, 32'h400,    2, 8'd63,  1'b0};

    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_addr", addr0, 32'd0);
    check("rst_alen", 32'(alen0), 32'd0);
    check("rst_size", 32'(size0), 32'd0);
    check("rst_strb", 32'(strb0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_errv", 32'(errv0), 32'd0);
    check("rst_erra", erra0, 32'd0);
    check("rst_errs", 32'(errs0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_job(i);

    // ready held low for 5 cycles: request must hold stable
    push_model(32'h6000, 32'h100, 10000);
    hs_cnt = 0;
    ready = 1'b0;
    do_go(32'h6000, 32'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(valid0), 32'd1);
      check("stall_hold_addr", addr0, 32'h6000);
      check("stall_hold_alen", 32'(alen0), 32'd63);
    end
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_done", 32'(done0), 32'd1);
    check("stall_nreq", 32'(hs_cnt), 32'd1);

    // Abort without handshake in cycle 3 of a 3-burst job
    push_model(32'h1000, 32'hC00, 2);
    hs_cnt = 0;
    ready = 1'b1;
    do_go(32'h1000, 32'hC00);
    @(posedge clk); #1;
    @(posedge clk); #1 ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_valid", 32'(valid0), 32'd0);
      check("abort_done", 32'(done0), 32'd0);
    end
    check("abort_nreq", 32'(hs_cnt), 32'd2);
    check("abort_queue", 32'(q.size()), 32'd0);

    // Abort together with a handshake: that burst counts, then idle
    push_model(32'h1000, 32'hC00, 1);
    hs_cnt = 0;
    do_go(32'h1000, 32'hC00);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_hs_valid", 32'(valid0), 32'd0);
      check("abort_hs_done", 32'(done0), 32'd0);
    end
    check("abort_hs_nreq", 32'(hs_cnt), 32'd1);

    // Asynchronous reset in the middle of a job
    push_model(32'h1000, 32'hC00, 10000);
    ready = 1'b0;
    do_go(32'h1000, 32'hC00);
    @(negedge clk);
    check("prerst_valid", 32'(valid0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_addr", addr0, 32'd0);
    check("arst_alen", 32'(alen0), 32'd0);
    check("arst_done", 32'(done0), 32'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("postrst_valid", 32'(valid0), 32'd0);
    check("postrst_done", 32'(done0), 32'd0);
    run_job(0);

    // Single-beat write-side instance: 512 requests of alen 0 from dst
    src = 32'h1003; dst = 32'h2000; nbytes = 32'h800; ready = 1'b1;
    @(posedge clk); #1 go1 = 1'b1;
    @(posedge clk); #1 go1 = 1'b0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      check("single_valid", 32'(valid1), 32'd1);
      check("single_addr", addr1, 32'h2000 + 32'(k) * 32'd4);
      check("single_alen", 32'(alen1), 32'd0);
    end
    @(negedge clk);
    check("single_done", 32'(done1), 32'd1);
    check("single_valid_end", 32'(valid1), 32'd0);
    check("single_no_err", 32'(errv1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
